// File: rtl/lcd_cmd_scheduler_pkg.sv
// Shared definitions for the LCD command scheduler: opcodes, the shift
// window bounds, the scheduler FSM states and the no-op shift predicate.
package lcd_pkg;

  localparam logic [3:0] OP_WRITE = 4'd0;
  localparam logic [3:0] OP_UP    = 4'd1;
  localparam logic [3:0] OP_DOWN  = 4'd2;
  localparam logic [3:0] OP_LEFT  = 4'd3;
  localparam logic [3:0] OP_RIGHT = 4'd4;
  localparam logic [3:0] OP_MAX   = 4'd5;
  localparam logic [3:0] OP_MIN   = 4'd6;
  localparam logic [3:0] OP_AVG   = 4'd7;

  // The controller's image window can only move between these positions.
  localparam logic [2:0] WIN_LO    = 3'd2;
  localparam logic [2:0] WIN_HI    = 3'd6;
  localparam logic [2:0] POS_START = 3'd4;

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_HOLD      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } sched_state_e;

  // True when a shift would push the window past its bound, so the
  // controller would ignore it anyway.
  function automatic logic is_noop_shift(input logic [3:0] op,
                                         input logic [2:0] x,
                                         input logic [2:0] y);
    logic r;
    r = 1'b0;
    case (op)
      OP_UP:    r = !(y > WIN_LO);
      OP_DOWN:  r = !(y < WIN_HI);
      OP_LEFT:  r = !(x > WIN_LO);
      OP_RIGHT: r = !(x < WIN_HI);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_cmd_scheduler_if.sv
// Host-side handshake and LCD-controller bus of the command scheduler.
// The scheduler takes the slave view; the host/controller side the master.
interface lcd_cmd_scheduler_if;
  import lcd_pkg::*;

  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;

  modport slave (
    input  host_cmd, host_valid, busy, done,
    output host_ready, cmd, cmd_valid
  );

  modport master (
    output host_cmd, host_valid, busy, done,
    input  host_ready, cmd, cmd_valid
  );

endinterface

// File: rtl/lcd_cmd_scheduler_fifo.sv
// Small synchronous command FIFO, DEPTH x 4 bits, with a flush input.
// Pointers carry one extra wrap bit to tell full from empty.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [3:0]               i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [3:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointer update; a flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// LCD command scheduler: queues host commands and issues them one at a
// time to the LCD controller when it is idle, holding each command for
// the controller's execute cycle. A WRITE ends the session.
// Optional feature macro: LCD_SCHED_FILTER_EN drops shifts that would
// hit the window boundary, tracking a shadow window position.
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lcd_cmd_scheduler_if.slave      bus,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_inval,
  output logic [CNT_W-1:0]        filt_cnt,
  output logic                    sched_done
);

  sched_state_e r_state;
  logic [3:0]   r_cmd;
  logic         r_cmd_valid;
  logic         r_err_inval;
  logic         r_sched_done;

  logic         w_full;
  logic         w_empty;
  logic [3:0]   w_head;
  logic         w_push_hs;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_issue;
  logic         w_drop;

  assign bus.host_ready = !w_full && (r_state != ST_FINISH) &&
                          (r_state != ST_WAIT_DONE);
  assign w_push_hs = bus.host_valid && bus.host_ready;
  assign w_push    = w_push_hs && (bus.host_cmd <= OP_AVG);
  assign w_flush   = (r_state == ST_WAIT_DONE) && bus.done;
  assign w_issue   = (r_state == ST_READY) && !w_empty && !bus.busy && !w_drop;
  assign w_pop     = w_issue || w_drop;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.host_cmd),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

`ifdef LCD_SCHED_FILTER_EN
  logic [2:0]       r_pos_x;
  logic [2:0]       r_pos_y;
  logic [CNT_W-1:0] r_filt_cnt;

  assign w_drop = (r_state == ST_READY) && !w_empty &&
                  is_noop_shift(w_head, r_pos_x, r_pos_y);

  // Shadow of the controller's window position, moved by issued shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x <= POS_START;
      r_pos_y <= POS_START;
    end else if (w_issue) begin
      case (w_head)
        OP_UP:    r_pos_y <= r_pos_y - 3'd1;
        OP_DOWN:  r_pos_y <= r_pos_y + 3'd1;
        OP_LEFT:  r_pos_x <= r_pos_x - 3'd1;
        OP_RIGHT: r_pos_x <= r_pos_x + 3'd1;
        default:  ;
      endcase
    end
  end

  // Saturating count of shifts dropped because they would be no-ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
    end else if (w_drop && (r_filt_cnt != '1)) begin
      r_filt_cnt <= r_filt_cnt + CNT_W'(1);
    end
  end

  assign filt_cnt = r_filt_cnt;
`else
  assign w_drop   = 1'b0;
  assign filt_cnt = '0;
`endif

  // Issue sequencing: strobe one cycle, hold through the execute cycle,
  // and after a WRITE wait for write-out completion then stop for good.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_READY;
      r_cmd        <= '0;
      r_cmd_valid  <= 1'b0;
      r_sched_done <= 1'b0;
    end else begin
      case (r_state)
        ST_READY: begin
          if (w_issue) begin
            r_cmd       <= w_head;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cmd_valid <= 1'b0;
          r_state     <= (r_cmd == OP_WRITE) ? ST_WAIT_DONE : ST_HOLD;
        end
        ST_HOLD: begin
          r_state <= ST_READY;
        end
        ST_WAIT_DONE: begin
          if (bus.done) begin
            r_sched_done <= 1'b1;
            r_state      <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_FINISH;
        end
        default: begin
          r_state <= ST_READY;
        end
      endcase
    end
  end

  // Sticky flag for any out-of-range opcode the host handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_inval <= 1'b0;
    end else if (w_push_hs && (bus.host_cmd > OP_AVG)) begin
      r_err_inval <= 1'b1;
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.cmd_valid = r_cmd_valid;
  assign err_inval     = r_err_inval;
  assign sched_done    = r_sched_done;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Testbench for lcd_cmd_scheduler. Expected issued opcodes are queued as
// commands are pushed; a monitor pops and compares on every cmd_valid.
module tb_lcd_cmd_scheduler;
  import lcd_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  lcd_cmd_scheduler_if bus();
  logic [$clog2(DEPTH):0] fifoCount;
  logic                   errInval;
  logic [CNT_W-1:0]       filtCnt;
  logic                   schedDone;

  int         checks = 0;
  int         errors = 0;
  int         cycCount = 0;
  int         issueCount = 0;
  int         issueCycles[$];
  logic [3:0] expQ[$];
  int         lastPushCycle = 0;

  lcd_cmd_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_count (fifoCount),
    .err_inval  (errInval),
    .filt_cnt   (filtCnt),
    .sched_done (schedDone)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycCount++;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the next expected opcode, and
  // strobes must be at least three cycles apart.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.cmd_valid) begin
        issueCount++;
        issueCycles.push_back(cycCount);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_issue: got cmd %0d, expected no issue", bus.cmd);
        end else begin
          checkOutput("issue_cmd", int'(bus.cmd), int'(expQ.pop_front()));
        end
        if (issueCycles.size() >= 2)
          checkOutput("issue_gap_ge3",
                      int'((issueCycles[$] - issueCycles[$-1]) >= 3), 1);
      end
    end
  end

  // Controller model: completes write-out 66 cycles after a WRITE strobe.
  initial begin
    bus.done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cmd_valid && (bus.cmd == OP_WRITE)) begin
        repeat (66) @(posedge clk);
        #1 bus.done = 1'b1;
        @(posedge clk);
        #1 bus.done = 1'b0;
      end
    end
  end

  // Holds host_valid until the handshake edge, bounded by a cycle budget.
  task automatic finishHandshake();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.host_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    lastPushCycle = cycCount;
    bus.host_valid = 1'b0;
    checkOutput("push_handshake", int'(ok), 1);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input bit expIssue);
    bus.host_cmd   = op;
    bus.host_valid = 1'b1;
    if (expIssue) expQ.push_back(op);
    finishHandshake();
  endtask

  // Asynchronous reset, checked before any clock edge can occur.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_cmd", int'(bus.cmd), 0);
    checkOutput("rst_cmd_valid", int'(bus.cmd_valid), 0);
    checkOutput("rst_fifo_count", int'(fifoCount), 0);
    checkOutput("rst_err_inval", int'(errInval), 0);
    checkOutput("rst_filt_cnt", int'(filtCnt), 0);
    checkOutput("rst_sched_done", int'(schedDone), 0);
    checkOutput("rst_host_ready", int'(bus.host_ready), 1);
    expQ.delete();
    issueCycles.delete();
    issueCount = 0;
    bus.host_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checkOutput(name, expQ.size(), 0);
  endtask

  function automatic int gapAt(input int i);
    if (issueCycles.size() > i + 1) return issueCycles[i+1] - issueCycles[i];
    return -1;
  endfunction

  initial begin
    #500000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int pMax;
    rst_n          = 1'b0;
    bus.host_cmd   = 4'd0;
    bus.host_valid = 1'b0;
    bus.busy       = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    // Load phase: controller busy, three commands wait in the FIFO.
    bus.busy = 1'b1;
    applyStimulus(OP_UP, 1'b1);
    applyStimulus(OP_RIGHT, 1'b1);
    applyStimulus(OP_MAX, 1'b1);
    repeat (67) @(posedge clk);
    #1;
    checkOutput("load_no_issue", issueCount, 0);
    checkOutput("load_fifo_count", int'(fifoCount), 3);
    bus.busy = 1'b0;
    waitDrain("load_drain", 50);
    checkOutput("load_issue_count", issueCount, 3);
    checkOutput("load_gap1", gapAt(0), 3);
    checkOutput("load_gap2", gapAt(1), 3);

    // Simultaneous push and pop leaves occupancy unchanged.
    doReset();
    bus.busy = 1'b1;
    applyStimulus(OP_UP, 1'b1);
    applyStimulus(OP_DOWN, 1'b1);
    bus.busy = 1'b0;
    applyStimulus(OP_MAX, 1'b1);
    checkOutput("simul_fifo_count", int'(fifoCount), 2);
    waitDrain("simul_drain", 50);

    // Backpressure: eight fill the FIFO, the ninth waits for a pop.
    doReset();
    bus.busy = 1'b1;
    applyStimulus(OP_MAX, 1'b1);
    applyStimulus(OP_MIN, 1'b1);
    applyStimulus(OP_AVG, 1'b1);
    applyStimulus(OP_UP, 1'b1);
    applyStimulus(OP_DOWN, 1'b1);
    applyStimulus(OP_LEFT, 1'b1);
    applyStimulus(OP_RIGHT, 1'b1);
    applyStimulus(OP_MAX, 1'b1);
    bus.host_cmd   = OP_MIN;
    bus.host_valid = 1'b1;
    expQ.push_back(OP_MIN);
    @(posedge clk);
    #1;
    checkOutput("bp_host_ready_low", int'(bus.host_ready), 0);
    checkOutput("bp_fifo_full_count", int'(fifoCount), 8);
    bus.busy = 1'b0;
    finishHandshake();
    checkOutput("bp_count_after_refill", int'(fifoCount), 8);
    waitDrain("bp_drain", 100);
    checkOutput("bp_issue_count", issueCount, 9);

    // Write-out: MIN behind the WRITE is flushed, never issued.
    doReset();
    applyStimulus(OP_MAX, 1'b1);
    pMax = lastPushCycle;
    applyStimulus(OP_WRITE, 1'b1);
    applyStimulus(OP_MIN, 1'b0);
    lat = (issueCycles.size() > 0) ? issueCycles[0] - pMax : -1;
    checkOutput("first_issue_latency", lat, 1);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("wd_sched_done_low", int'(schedDone), 0);
    checkOutput("wd_host_ready_low", int'(bus.host_ready), 0);
    checkOutput("wd_fifo_count", int'(fifoCount), 1);
    for (int i = 0; i < 200 && !schedDone; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("wo_sched_done", int'(schedDone), 1);
    checkOutput("wo_fifo_flushed", int'(fifoCount), 0);
    checkOutput("wo_host_ready", int'(bus.host_ready), 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("wo_issue_count", issueCount, 2);
    checkOutput("wo_sched_done_sticky", int'(schedDone), 1);

    // Invalid opcode: flagged, consumed, not stored.
    doReset();
    bus.busy = 1'b1;
    applyStimulus(OP_AVG, 1'b1);
    checkOutput("inv_err_before", int'(errInval), 0);
    applyStimulus(4'd9, 1'b0);
    checkOutput("inv_err_set", int'(errInval), 1);
    checkOutput("inv_fifo_count", int'(fifoCount), 1);
    bus.busy = 1'b0;
    waitDrain("inv_drain", 50);
    checkOutput("inv_issue_count", issueCount, 1);
    checkOutput("inv_err_sticky", int'(errInval), 1);

    // Filter: third UP reaches the top bound when filtering is built in.
    doReset();
    applyStimulus(OP_UP, 1'b1);
    applyStimulus(OP_UP, 1'b1);
`ifdef LCD_SCHED_FILTER_EN
    applyStimulus(OP_UP, 1'b0);
`else
    applyStimulus(OP_UP, 1'b1);
`endif
    applyStimulus(OP_AVG, 1'b1);
    waitDrain("filt_drain", 60);
`ifdef LCD_SCHED_FILTER_EN
    checkOutput("filt_cnt", int'(filtCnt), 1);
    checkOutput("filt_issue_count", issueCount, 3);
`else
    checkOutput("filt_cnt", int'(filtCnt), 0);
    checkOutput("filt_issue_count", issueCount, 4);
`endif

    // Reset in the middle of HOLD with commands still queued.
    doReset();
    applyStimulus(OP_LEFT, 1'b1);
    applyStimulus(OP_RIGHT, 1'b0);
    applyStimulus(OP_MIN, 1'b0);
    checkOutput("hold_cmd_before_rst", int'(bus.cmd), int'(OP_LEFT));
    checkOutput("hold_count_before_rst", int'(fifoCount), 2);
    doReset();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_no_issue", issueCount, 0);
    checkOutput("post_rst_fifo_count", int'(fifoCount), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_scheduler.md
# lcd_cmd_scheduler

Command scheduler that sits between a host command source and the LCD image controller (`cmd`/`cmd_valid`/`busy`/`done`). It buffers host commands in a small FIFO. It issues each command to the controller only when the controller is idle, and holds the command stable through the controller's execute cycle. After the final write-out command it stops accepting traffic. Optionally, it filters out shift commands that would hit the 2..6 window boundary and therefore have no effect.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `CNT_W`, 8 — width of the filtered-command counter.
- `clk` in 1 — clock; all state changes on the rising edge.
- `rst_n` in 1 — reset; one clock, reset is asynchronous and active-low.
- `host_cmd` in 4 — host command opcode.
- `host_valid` in 1 — host command present.
- `host_ready` out 1 — scheduler accepts `host_cmd` this cycle.
- `cmd` out 4 — opcode to the LCD controller (registered).
- `cmd_valid` out 1 — issue strobe to the LCD controller (registered).
- `busy` in 1 — LCD controller busy.
- `done` in 1 — LCD controller finished write-out.
- `fifo_count` out $clog2(DEPTH)+1 — current FIFO occupancy.
- `err_inval` out 1 — sticky flag: an opcode >7 was offered.
- `filt_cnt` out CNT_W — count of dropped no-op shifts; saturates at the top value. Reads 0 when the filter is compiled out.
- `sched_done` out 1 — sticky flag: `done` has been seen.

## Operation
- Push condition: `host_valid && host_ready`. `host_ready = !full && state!=FINISH && state!=WAIT_DONE`.
- Opcode >7 on a push:
  - not stored;
  - `err_inval` ← 1 (held until reset);
  - still consumes the handshake.
- Opcodes: 0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 MAX, 6 MIN, 7 AVG.
- FSM: READY, ISSUE, HOLD, WAIT_DONE, FINISH.
- READY:
  - Condition: FIFO not empty and `busy==0`.
  - Action: register `cmd` ← head, `cmd_valid` ← 1, pop; go to ISSUE.
  - Otherwise stay in READY.
- ISSUE:
  - `cmd_valid` ← 0, `cmd` held.
  - Go to WAIT_DONE if the issued opcode was WRITE, else HOLD.
- HOLD:
  - `cmd` held; `busy` ignored.
  - Go to READY.
- WAIT_DONE:
  - Wait for `done==1`.
  - Then `sched_done` ← 1, FIFO flushed (count → 0); go to FINISH.
- FINISH: terminal; `host_ready=0`; no further issues.
- Commands queued behind a WRITE are discarded at the flush.
- Simultaneous push and pop: occupancy unchanged. Push while full is impossible because `host_ready=0`.
- Pointer wrap: modulo DEPTH, using an extra pointer bit for full/empty.
- `busy` high from reset (controller image load) keeps the scheduler in READY with no issue.
- Async reset mid-operation:
  - FSM → READY;
  - FIFO empty;
  - all outputs to their reset values immediately.

## Timing
- Reset values: `cmd=0`, `cmd_valid=0`, `fifo_count=0`, `err_inval=0`, `filt_cnt=0`, `sched_done=0`, `host_ready=1`.
- Push at edge P into an empty FIFO with `busy=0`: `cmd_valid=1` from edge P+1, for exactly one cycle.
- `cmd` stays stable from the issue edge through the end of HOLD (2 cycles after the strobe).
- Minimum spacing between `cmd_valid` pulses: 3 cycles.
- `fifo_count` updates on the edge after the handshake.
- `sched_done` rises on the edge after `done` is first sampled high.

## Configuration
- Macro: `LCD_SCHED_FILTER_EN`.
- With the macro defined:
  - Shadow position (x,y) resets to (4,4) and updates on every issued shift.
  - Shadow bounds: UP needs y>2, DOWN needs y<6, LEFT needs x>2, RIGHT needs x<6.
  - A head shift that fails its bound is popped in READY without an issue; `filt_cnt` +1. This costs 1 cycle and does not require `busy==0`.
- Without the macro: no shadow state; every command is issued; `filt_cnt` is tied to 0.

## Structure
- Package `lcd_pkg` holds:
  - opcode constants;
  - window bounds (2, 6) and start position 4;
  - the FSM state enum.
- Sub-module `lcd_cmd_fifo`:
  - synchronous FIFO, DEPTH×4;
  - push/pop/flush inputs;
  - full, empty and count outputs.

## Test plan
- Load phase:
  - Stimulus: `busy=1` for 70 cycles, 3 commands pushed.
  - Required: no `cmd_valid`, `fifo_count=3`. After `busy` falls, 3 strobes spaced 3 cycles apart, in order.
- Backpressure:
  - Stimulus: push 9 commands with `busy=1`.
  - Required: `host_ready` drops after 8, `fifo_count=8`. Simultaneous push and pop keeps the count at 8.
- Write-out:
  - Stimulus: push MAX, WRITE, MIN; model raises `done` 66 cycles after the WRITE.
  - Required: MIN is never issued, `sched_done=1`, `fifo_count=0`, `host_ready=0`.
- Invalid opcode:
  - Stimulus: push opcode 9.
  - Required: `err_inval=1`, `fifo_count` unchanged, no issue.
- Filter (with `LCD_SCHED_FILTER_EN`):
  - Stimulus: UP×3, then AVG.
  - Required: 2 UPs issued, `filt_cnt=1`, AVG issued. Without the macro: 3 UPs issued.
- Reset mid-HOLD:
  - Stimulus: `rst_n` low asynchronously.
  - Required: `cmd=0`, `cmd_valid=0`, `fifo_count=0` immediately, without waiting for a clock edge.
